// File: rtl/opb_slave_regbank_if.sv
// OPB bus signals between a master and the opb_slave_regbank responder.
// Bit 0 is the MSB on every vector, matching OPB numbering.
interface opb_slave_regbank_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_slave_regbank.sv
// OPB slave register bank: reg0 read-only ID, regs 1..NUM_REGS-1 read/write, programmable wait states.
// Define OPB_SLV_ERRACK_EN to complete unmapped accesses and reg0 writes with Sl_errAck.
module opb_slave_regbank #(
    parameter logic [31:0] C_BASEADDR  = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR  = 32'h0000_00FF,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] ID_VALUE    = 32'h4750_4D43
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    opb_slave_regbank_if.slave        opb,
    output logic [0:NUM_REGS*32-1]    user_regs,
    output logic                      user_wr,
    output logic [0:5]                user_wr_idx
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] SPAN  = C_HIGHADDR - C_BASEADDR;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_DONE} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] idx_q;
    logic        rnw_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] regs_q [NUM_REGS];

    logic [31:0] sl_dbus_q;
    logic        xfer_ack_q;
    logic        err_ack_q;
    logic        tout_sup_q;
    logic        user_wr_q;
    logic [5:0]  user_wr_idx_q;

    // Window decode; an address below the base wraps the offset past SPAN.
    logic [31:0] abus;
    logic [31:0] offset;
    logic [31:0] win_idx;
    logic        win_hit;

    assign abus    = opb.OPB_ABus;
    assign offset  = abus - C_BASEADDR;
    assign win_idx = {2'b00, offset[31:2]};
    assign win_hit = opb.OPB_select && (offset <= SPAN);

    logic [31:0] idx_d;
    logic        rnw_d;
    logic        idx_in_range;
    logic        err_d;
    logic        wr_ok_d;
    logic        go_ack_d;
    logic [31:0] rd_data_d;
    logic [31:0] ack_dbus_d;
    logic [31:0] wr_merge_d;

    // Response for the cycle about to enter ACK; with zero wait states it comes straight off the bus.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        idx_d        = (state_q == S_IDLE) ? win_idx : idx_q;
        rnw_d        = (state_q == S_IDLE) ? opb.OPB_RNW : rnw_q;
        idx_in_range = (idx_d < NUM_REGS);
        rd_data_d    = '0;
        if (idx_d == 32'd0) begin
            rd_data_d = ID_VALUE;
        end else if (idx_in_range) begin
            rd_data_d = regs_q[idx_d[IDX_W-1:0]];
        end
`ifdef OPB_SLV_ERRACK_EN
        err_d = !idx_in_range || (!rnw_d && (idx_d == 32'd0));
`else
        err_d = 1'b0;
`endif
        wr_ok_d    = !rnw_d && idx_in_range && (idx_d != 32'd0);
        ack_dbus_d = (rnw_d && !err_d) ? rd_data_d : '0;
        go_ack_d   = ((state_q == S_IDLE) && win_hit && (WAIT_STATES == 0)) ||
                     ((state_q == S_WAIT) && opb.OPB_select && (cnt_q == 4'd0));
    end

    always_comb begin
        wr_merge_d = regs_q[idx_q[IDX_W-1:0]];
        for (int b = 0; b < 4; b++) begin
            if (be_q[b]) wr_merge_d[8*b +: 8] = wdata_q[8*b +: 8];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            rnw_q         <= 1'b0;
            be_q          <= '0;
            wdata_q       <= '0;
            sl_dbus_q     <= '0;
            xfer_ack_q    <= 1'b0;
            err_ack_q     <= 1'b0;
            tout_sup_q    <= 1'b0;
            user_wr_q     <= 1'b0;
            user_wr_idx_q <= '0;
            // NOTE: this bank is flops visible to fabric, so it is reset; a RAM-style array would not be.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            sl_dbus_q  <= '0;
            xfer_ack_q <= 1'b0;
            err_ack_q  <= 1'b0;
            tout_sup_q <= 1'b0;
            user_wr_q  <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (win_hit) begin
                        idx_q   <= win_idx;
                        rnw_q   <= opb.OPB_RNW;
                        be_q    <= opb.OPB_BE;
                        wdata_q <= opb.OPB_DBus;
                        if (WAIT_STATES > 0) begin
                            state_q    <= S_WAIT;
                            cnt_q      <= 4'(WAIT_STATES - 1);
                            tout_sup_q <= 1'b1;
                        end else begin
                            state_q <= S_ACK;
                        end
                    end
                end
                S_WAIT: begin
                    if (!opb.OPB_select) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= S_ACK;
                    end else begin
                        cnt_q      <= cnt_q - 4'd1;
                        tout_sup_q <= 1'b1;
                    end
                end
                S_ACK: begin
                    state_q <= S_DONE;
                    if (wr_ok_d) regs_q[idx_q[IDX_W-1:0]] <= wr_merge_d;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            if (go_ack_d) begin
                xfer_ack_q <= !err_d;
                err_ack_q  <= err_d;
                sl_dbus_q  <= ack_dbus_d;
                user_wr_q  <= wr_ok_d;
                if (wr_ok_d) user_wr_idx_q <= idx_d[5:0];
            end
        end
    end

    always_comb begin
        user_regs       = '0;
        user_regs[0:31] = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) user_regs[i*32 +: 32] = regs_q[i];
    end

    assign opb.Sl_DBus    = sl_dbus_q;
    assign opb.Sl_xferAck = xfer_ack_q;
    assign opb.Sl_errAck  = err_ack_q;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = tout_sup_q;
    assign user_wr        = user_wr_q;
    assign user_wr_idx    = user_wr_idx_q;

    // Beats are always single and byte-lane address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{opb.OPB_seqAddr, offset[1:0]};

endmodule
